alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Sequencing front end for the 8-bit RISC datapath's `alu`: accepts instruction bytes over a valid/ready handshake, reads operands from a private 4×8 register file, drives the ALU operand/control inputs, captures the ALU result and writes it back. It is the producer side of the `alu` interface `(a, b, control, f, c)`. Its ALU-facing outputs connect port-for-port to `alu`. The block is multi-cycle with one instruction in flight.

## Interface
- No parameters. Data width is fixed at 8 bits and register count at 4.
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  `instr_byte` holds a valid byte this cycle
- `instr_byte`  in  8  instruction or immediate byte
- `instr_ready`  out  1  unit accepts a byte this cycle; transfer occurs when `instr_valid && instr_ready`
- `alu_a`  out  8  connects to `alu.a`
- `alu_b`  out  8  connects to `alu.b`
- `alu_ctrl`  out  3  connects to `alu.control`
- `alu_f`  out  1  connects to `alu.f`
- `alu_c`  in  8  connects to `alu.c` (combinational ALU result)
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when a register write completes (ALU op or LDI)
- `err`  out  1  one-cycle pulse when an illegal opcode is dropped
- `dbg_addr`  in  2  debug register select
- `dbg_data`  out  8  combinational read of `R[dbg_addr]`

## Operation
- Instruction byte fields: `[7:5]` op, `[4]` f, `[3:2]` rd, `[1:0]` rs. Semantics are `R[rd] <= R[rd] op R[rs]`.
- Legal ops:
  - 000 (f=1 NAND, f=0 NOR)
  - 011 (f=1 ADD, f=0 SUB, computed as a−b)
  - 100 (f=1 SRL, f=0 SLL)
  - 111 = LDI, a two-byte instruction: the next accepted byte is written to `R[rd]`; the f and rs fields are ignored.
- Ops 001, 010, 101 and 110 are illegal.
- FSM states are IDLE, EXEC, WB and IMM.
  - IDLE: `instr_ready`=1. On transfer:
    - legal ALU op: latch `alu_a`=R[rd], `alu_b`=R[rs], `alu_ctrl`=op, `alu_f`=f and the rd index, then go to EXEC
    - LDI: latch rd, then go to IMM
    - illegal op: pulse `err` on the next cycle and stay in IDLE
  - EXEC: `instr_ready`=0. ALU inputs are stable; capture `alu_c` into the result register at the end of the cycle, then go to WB.
  - WB: `instr_ready`=0. Write the result to `R[rd]` at the end of the cycle; `done`=1 during this cycle; then go to IDLE.
  - IMM: `instr_ready`=1. On transfer, write `instr_byte` to `R[rd]` and go to IDLE. `done` pulses in the following cycle, with the same registered-pulse style as `err`. Without a transfer, wait indefinitely.
- `alu_*` outputs change only on an IDLE accept of a legal ALU op; otherwise they hold their last values.
- Operands are read from the register file at accept time. Writeback always completes before the next accept, so there are no hazards. rd==rs is legal and uses the pre-op value for both operands.
- All arithmetic is mod 2^8. Carry and borrow are discarded.
- `instr_valid` while `instr_ready`=0 is ignored. The producer must hold the byte until it is accepted.

## Timing
- Reset values: state=IDLE, R0..R3=0x00, `alu_a`=`alu_b`=0x00, `alu_ctrl`=3'b000, `alu_f`=0, `busy`=0, `done`=0, `err`=0, `instr_ready`=1 (IDLE).
- ALU op latency, with accept in cycle N:
  - `alu_*` valid in N+1 (EXEC)
  - `done` high in N+2 (WB)
  - register visible on `dbg_data` in N+3
  - next accept possible in N+3
  - peak throughput: one ALU op per 3 cycles
- LDI: opcode accept in cycle N, immediate accept in cycle M>N (M=N+1 at the earliest); register written at the end of M; `done` high in M+1.
- Illegal op: accept in cycle N, `err` high in N+1; the unit can accept again in N+1.
- `rst` in any state, including mid-EXEC/WB/IMM, aborts the current operation with no writeback, no `done` and no `err` pulse. All outputs take their reset values on the next cycle.
- `done` and `err` are never high simultaneously.

## Test plan
- **LDI and dbg:** LDI R0 ← 0x0F, then LDI R1 ← 0x05 (bytes 0xE0,0x0F,0xE4,0x05) → `done` pulse after each immediate; `dbg_data` reads 0x0F at `dbg_addr`=0 and 0x05 at `dbg_addr`=1.
- **ADD/SUB with real `alu`:**
  - ADD R0,R1 (0x71) → EXEC shows `alu_a`=0x0F, `alu_b`=0x05, `alu_ctrl`=011, `alu_f`=1; R0=0x14, `done` in N+2.
  - Then SUB R0,R1 (0x61) → R0=0x0F.
- **NAND/NOR and wrap:** with R2=0xAA and R3=0x03:
  - NAND R2,R3 (0x1B) → R2=0xFD
  - R0=0xFF, then ADD R0 with R1=0x01 → R0=0x00 (wrap)
- **Illegal op and ignored valid:**
  - byte 0x20 → `err` in N+1, registers unchanged, `instr_ready` still 1
  - `instr_valid` held high with junk during EXEC/WB → ignored
- **Reset mid-op:** accept ADD, assert `rst` during EXEC → no `done`, R0..R3=0x00, `alu_*`=0, state IDLE next cycle.
- **LDI stall:** send 0xE8, then hold `instr_valid`=0 for 5 cycles → `busy`=1 and `instr_ready`=1 throughout; then 0x3C → R2=0x3C, `done` one cycle later.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Multi-cycle issue/writeback sequencer for the 8-bit alu: fetches instruction
// bytes, drives ALU operands from a private 4x8 register file, writes results back.
module alu_issue_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr_byte,
  output logic       instr_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_ctrl,
  output logic       alu_f,
  input  logic [7:0] alu_c,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [1:0] dbg_addr,
  output logic [7:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, IMM} state_t;

  state_t     state;
  logic [7:0] regs [4];
  logic [1:0] rd_q;
  logic [7:0] result;

  logic [2:0] op;
  logic       fbit;
  logic [1:0] rd, rs;
  logic       xfer, op_alu, op_ldi;

  always_comb begin
    op     = instr_byte[7:5];
    fbit   = instr_byte[4];
    rd     = instr_byte[3:2];
    rs     = instr_byte[1:0];
    op_alu = (op == 3'b000) || (op == 3'b011) || (op == 3'b100);
    op_ldi = (op == 3'b111);
    instr_ready = (state == IDLE) || (state == IMM);
    busy        = (state != IDLE);
    xfer        = instr_valid && instr_ready;
    dbg_data    = regs[dbg_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      regs     <= '{default: '0};
      rd_q     <= '0;
      result   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
      alu_f    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer) begin
            if (op_alu) begin
              alu_a    <= regs[rd];
              alu_b    <= regs[rs];
              alu_ctrl <= op;
              alu_f    <= fbit;
              rd_q     <= rd;
              state    <= EXEC;
            end else if (op_ldi) begin
              rd_q  <= rd;
              state <= IMM;
            end else begin
              err <= 1'b1;
            end
          end
        end
        EXEC: begin
          result <= alu_c;
          // done is registered, so raising it here makes it high for the WB cycle
          done   <= 1'b1;
          state  <= WB;
        end
        WB: begin
          regs[rd_q] <= result;
          state      <= IDLE;
        end
        IMM: begin
          if (xfer) begin
            regs[rd_q] <= instr_byte;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed scoreboard bench for alu_issue_unit with a behavioural alu attached.
module tb_alu_issue_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [7:0] instr_byte = 8'h00;
  logic       instr_ready;
  logic [7:0] alu_a, alu_b, alu_c;
  logic [2:0] alu_ctrl;
  logic       alu_f;
  logic       busy, done, err;
  logic [1:0] dbg_addr = 2'd0;
  logic [7:0] dbg_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] rd;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mreg [4];
  logic [2:0] last_ctrl;
  logic [7:0] last_a;

  alu_issue_unit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_byte(instr_byte),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_f(alu_f), .alu_c(alu_c), .busy(busy), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] calc(input logic [2:0] c, input logic f,
                                      input logic [7:0] a, input logic [7:0] b);
    case (c)
      3'b000:  return f ? ~(a & b) : ~(a | b);
      3'b011:  return f ? a + b : a - b;
      3'b100:  return f ? (a >> 1) : (a << 1);
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_c = calc(alu_ctrl, alu_f, alu_a, alu_b);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h, expected %02h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int unsigned n = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_byte  = b;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("accept_timeout", {7'd0, instr_ready}, 8'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_byte  = 8'h00;
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, dbg_data, ~dbg_data);
    end else begin
      e = sb.pop_front();
      dbg_addr = e.rd;
      #1;
      chk(tag, dbg_data, e.val);
      mreg[e.rd] = e.val;
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk(tag, dbg_data, mreg[i]);
    end
  endtask

  task automatic alu_op(input logic [7:0] b, input bit junk);
    logic [7:0] a, bb;
    a  = mreg[b[3:2]];
    bb = mreg[b[1:0]];
    sb.push_back('{b[3:2], calc(b[7:5], b[4], a, bb)});
    send(b);
    if (junk) begin
      instr_valid = 1'b1;
      instr_byte  = 8'hE4;
    end
    @(negedge clk);
    chk("exec_a", alu_a, a);
    chk("exec_b", alu_b, bb);
    chk("exec_ctrl", {5'd0, alu_ctrl}, {5'd0, b[7:5]});
    chk("exec_f", {7'd0, alu_f}, {7'd0, b[4]});
    chk("exec_ready", {7'd0, instr_ready}, 8'd0);
    chk("exec_busy", {7'd0, busy}, 8'd1);
    chk("exec_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    chk("wb_done", {7'd0, done}, 8'd1);
    chk("wb_err", {7'd0, err}, 8'd0);
    chk("wb_ready", {7'd0, instr_ready}, 8'd0);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("post_done", {7'd0, done}, 8'd0);
    chk("post_busy", {7'd0, busy}, 8'd0);
    check_pop("alu_wb");
    last_ctrl = b[7:5];
    last_a    = a;
  endtask

  task automatic ldi(input logic [1:0] rd, input logic [7:0] imm, input int stall);
    send({3'b111, 1'b0, rd, 2'b00});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("imm_busy", {7'd0, busy}, 8'd1);
      chk("imm_ready", {7'd0, instr_ready}, 8'd1);
      chk("imm_done", {7'd0, done}, 8'd0);
    end
    sb.push_back('{rd, imm});
    send(imm);
    @(negedge clk);
    chk("ldi_done", {7'd0, done}, 8'd1);
    chk("ldi_busy", {7'd0, busy}, 8'd0);
    check_pop("ldi_wb");
    @(negedge clk);
    chk("ldi_done_clr", {7'd0, done}, 8'd0);
  endtask

  task automatic illegal(input logic [7:0] b);
    send(b);
    @(negedge clk);
    chk("ill_err", {7'd0, err}, 8'd1);
    chk("ill_done", {7'd0, done}, 8'd0);
    chk("ill_ready", {7'd0, instr_ready}, 8'd1);
    chk("ill_busy", {7'd0, busy}, 8'd0);
    chk("ill_hold_ctrl", {5'd0, alu_ctrl}, {5'd0, last_ctrl});
    chk("ill_hold_a", alu_a, last_a);
    chk_regs("ill_regs");
    @(negedge clk);
    chk("ill_err_clr", {7'd0, err}, 8'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    last_ctrl = 3'b000;
    last_a    = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {7'd0, instr_ready}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    chk("rst_a", alu_a, 8'h00);
    chk("rst_b", alu_b, 8'h00);
    chk("rst_ctrl", {5'd0, alu_ctrl}, 8'd0);
    chk("rst_f", {7'd0, alu_f}, 8'd0);
    chk_regs("rst_regs");

    ldi(2'd0, 8'h0F, 0);
    ldi(2'd1, 8'h05, 0);
    chk_regs("ldi_regs");
    alu_op(8'h71, 1'b0);                  // ADD R0,R1 -> 0x14
    chk("add_r0", mreg[0], 8'h14);
    alu_op(8'h61, 1'b0);                  // SUB R0,R1 -> 0x0F
    chk("sub_r0", mreg[0], 8'h0F);

    ldi(2'd2, 8'hAA, 0);
    ldi(2'd3, 8'h03, 0);
    alu_op(8'h1B, 1'b0);                  // NAND R2,R3 -> 0xFD
    chk("nand_r2", mreg[2], 8'hFD);
    alu_op(8'h0B, 1'b0);                  // NOR R2,R3 -> 0x00
    ldi(2'd0, 8'hFF, 0);
    ldi(2'd1, 8'h01, 0);
    alu_op(8'h71, 1'b0);                  // ADD wraps to 0x00
    chk("add_wrap", mreg[0], 8'h00);
    alu_op(8'h61, 1'b0);                  // SUB borrows to 0xFF
    alu_op(8'h9F, 1'b0);                  // SRL R3,R3 (rd==rs)
    alu_op(8'h8D, 1'b0);                  // SLL R3,R1

    illegal(8'h20);
    illegal(8'hA0);
    alu_op(8'h75, 1'b1);                  // junk held valid during EXEC/WB
    chk("junk_err", {7'd0, err}, 8'd0);
    chk_regs("junk_regs");

    ldi(2'd2, 8'h3C, 5);
    chk_regs("stall_regs");

    send(8'h71);
    @(negedge clk);
    chk("mid_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    @(negedge clk);
    chk("mrst_busy", {7'd0, busy}, 8'd0);
    chk("mrst_ready", {7'd0, instr_ready}, 8'd1);
    chk("mrst_done", {7'd0, done}, 8'd0);
    chk("mrst_err", {7'd0, err}, 8'd0);
    chk("mrst_a", alu_a, 8'h00);
    chk("mrst_b", alu_b, 8'h00);
    chk("mrst_ctrl", {5'd0, alu_ctrl}, 8'd0);
    chk("mrst_f", {7'd0, alu_f}, 8'd0);
    chk_regs("mrst_regs");
    @(negedge clk);
    chk("mrst_done2", {7'd0, done}, 8'd0);
    chk_regs("mrst_regs2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
